// File: rtl/switch_playback_sequencer.sv
// switch_playback_sequencer
// Plays switch patterns from a FIFO onto the RF switch pins at a programmed dwell rate.
// After an accepted arm it waits for a sync strobe, then pops one pattern per dwell period
// and holds each on the switches for exactly D = max(dwell_cycles, 2) cycles.
//
// Ports:
//   clock, reset         - single clock; synchronous active-low reset
//   arm, abort, sync     - start request, stop request (highest priority), frame strobe
//   dwell_cycles         - hold time per pattern, latched at arm
//   num_patterns         - number of patterns to play, latched at arm
//   fifo_empty/fifo_data - FIFO read side; data valid the cycle after fifo_rd
//   fifo_rd              - combinational pop request, never asserted while fifo_empty
//   switches/_valid      - registered switch drive and pattern-active flag
//   busy, done, underrun - status: not idle, one-cycle completion pulse, sticky starvation
//   played_count         - patterns loaded since last accepted arm (saturating)
module switch_playback_sequencer #(
  parameter int unsigned NUM_SWITCHES = 7,
  parameter int unsigned DWELL_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter logic [NUM_SWITCHES-1:0] IDLE_PATTERN = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sync,
  input  logic [DWELL_WIDTH-1:0]  dwell_cycles,
  input  logic [COUNT_WIDTH-1:0]  num_patterns,
  input  logic                    fifo_empty,
  input  logic [NUM_SWITCHES-1:0] fifo_data,
  output logic                    fifo_rd,
  output logic [NUM_SWITCHES-1:0] switches,
  output logic                    switches_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun,
  output logic [COUNT_WIDTH-1:0]  played_count
);

  typedef enum logic [1:0] {StIdle, StWaitSync, StLoad, StDwell} state_e;

  localparam logic [DWELL_WIDTH-1:0] CntOne = DWELL_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] CntTwo = DWELL_WIDTH'(2);

  state_e                    state_q, state_d;
  logic [DWELL_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DWELL_WIDTH-1:0]    dwell_q, dwell_d;
  logic [COUNT_WIDTH-1:0]    num_q, num_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [NUM_SWITCHES-1:0]   switches_q, switches_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      underrun_q, underrun_d;

  logic                      pending;
  logic [DWELL_WIDTH-1:0]    dwell_eff;
  logic [COUNT_WIDTH-1:0]    count_inc;

  assign pending   = (count_q < num_q);
  assign dwell_eff = (dwell_cycles < CntTwo) ? CntTwo : dwell_cycles;
  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    num_d      = num_q;
    count_d    = count_q;
    switches_d = switches_q;
    valid_d    = valid_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    fifo_rd    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort in the same cycle suppresses arm
        if (arm && !abort) begin
          dwell_d    = dwell_eff;
          num_d      = num_patterns;
          count_d    = '0;
          underrun_d = 1'b0;
          if (num_patterns == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StWaitSync;
          end
        end
      end
      StWaitSync: begin
        if (sync) begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            state_d = StLoad;
          end else begin
            underrun_d = 1'b1;
            done_d     = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StLoad: begin
        switches_d = fifo_data;
        valid_d    = 1'b1;
        count_d    = count_inc;
        cnt_d      = dwell_q;
        state_d    = StDwell;
      end
      StDwell: begin
        cnt_d = cnt_q - 1'b1;
        // pop two cycles ahead so the word is on fifo_data when cnt reaches 1
        if (cnt_q == CntTwo && pending) begin
          if (!fifo_empty) fifo_rd = 1'b1;
          else             underrun_d = 1'b1;
        end
        if (cnt_q == CntOne) begin
          if (pending && !underrun_q) begin
            switches_d = fifo_data;
            count_d    = count_inc;
            cnt_d      = dwell_q;
          end else begin
            switches_d = IDLE_PATTERN;
            valid_d    = 1'b0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // abort overrides everything; a word popped last cycle is simply never loaded
    if (abort && state_q != StIdle) begin
      fifo_rd    = 1'b0;
      state_d    = StIdle;
      cnt_d      = cnt_q;
      count_d    = count_q;
      underrun_d = underrun_q;
      switches_d = IDLE_PATTERN;
      valid_d    = 1'b0;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dwell_q    <= '0;
      num_q      <= '0;
      count_q    <= '0;
      switches_q <= IDLE_PATTERN;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      num_q      <= num_d;
      count_q    <= count_d;
      switches_q <= switches_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign switches       = switches_q;
  assign switches_valid = valid_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign underrun       = underrun_q;
  assign played_count   = count_q;

endmodule

// File: tb/tb_switch_playback_sequencer.sv
// Directed bench for switch_playback_sequencer with a simple FIFO model on the read side.
module tb_switch_playback_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] dwell_cycles = '0;
  logic [15:0] num_patterns = '0;
  logic        fifo_empty;
  logic [6:0]  fifo_data = '0;
  logic        fifo_rd;
  logic [6:0]  switches;
  logic        switches_valid;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [15:0] played_count;

  int n_asserts = 0;
  int n_fails   = 0;

  // FIFO model: wr_ptr owned by the initial block, rd_ptr by the pop process
  logic [6:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always #5 clock = ~clock;

  switch_playback_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .arm            (arm),
    .abort          (abort),
    .sync           (sync),
    .dwell_cycles   (dwell_cycles),
    .num_patterns   (num_patterns),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_rd        (fifo_rd),
    .switches       (switches),
    .switches_valid (switches_valid),
    .busy           (busy),
    .done           (done),
    .underrun       (underrun),
    .played_count   (played_count)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [6:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check a pattern held for d cycles; pop expected at the cnt=2 cycle when pop=1
  task automatic check_pattern(input string tag, input logic [6:0] pat, input int d,
                               input bit pop);
    for (int c = 0; c < d; c++) begin
      check({tag, "_sw"}, 32'(switches), 32'(pat));
      check({tag, "_valid"}, 32'(switches_valid), 32'd1);
      check({tag, "_rd"}, 32'(fifo_rd), (pop && c == d - 2) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  task automatic arm_run(input logic [15:0] n, input logic [15:0] d);
    arm = 1'b1;
    num_patterns = n;
    dwell_cycles = d;
    tick();
    arm = 1'b0;
  endtask

  // Sync with a non-empty FIFO: pop in the sync cycle, LOAD next, pattern after that
  task automatic do_sync(input string tag);
    sync = 1'b1;
    #1;
    check({tag, "_sync_rd"}, 32'(fifo_rd), 32'd1);
    tick();
    sync = 1'b0;
    #1;
    check({tag, "_load_sw"}, 32'(switches), 32'd0);
    tick();
  endtask

  task automatic check_end(input string tag, input logic [15:0] cnt, input logic urun);
    check({tag, "_end_sw"}, 32'(switches), 32'd0);
    check({tag, "_end_valid"}, 32'(switches_valid), 32'd0);
    check({tag, "_end_done"}, 32'(done), 32'd1);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_count"}, 32'(played_count), 32'(cnt));
    check({tag, "_end_underrun"}, 32'(underrun), 32'(urun));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    reset = 1'b1;
    check("rst_sw", 32'(switches), 32'd0);
    check("rst_valid", 32'(switches_valid), 32'd0);
    check("rst_rd", 32'(fifo_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_count", 32'(played_count), 32'd0);

    // Basic playback: N=3, D=4
    push(7'h11); push(7'h22); push(7'h33);
    arm_run(16'd3, 16'd4);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_wait_rd", 32'(fifo_rd), 32'd0);
    do_sync("t1");
    check_pattern("t1_p0", 7'h11, 4, 1'b1);
    check_pattern("t1_p1", 7'h22, 4, 1'b1);
    check_pattern("t1_p2", 7'h33, 4, 1'b0);
    check_end("t1", 16'd3, 1'b0);

    // D=0 is treated as 2
    push(7'h44); push(7'h55); push(7'h66);
    arm_run(16'd3, 16'd0);
    do_sync("t2");
    check_pattern("t2_p0", 7'h44, 2, 1'b1);
    check_pattern("t2_p1", 7'h55, 2, 1'b1);
    check_pattern("t2_p2", 7'h66, 2, 1'b0);
    check_end("t2", 16'd3, 1'b0);

    // Underrun: two words, N=3, D=5
    push(7'h77); push(7'h08);
    arm_run(16'd3, 16'd5);
    do_sync("t3");
    check_pattern("t3_p0", 7'h77, 5, 1'b1);
    check_pattern("t3_p1", 7'h08, 4, 1'b0);
    check("t3_underrun_set", 32'(underrun), 32'd1);
    check("t3_last_sw", 32'(switches), 32'h08);
    tick();
    check_end("t3", 16'd2, 1'b1);

    // Abort during second pattern, then re-arm plays the next word
    push(7'h01); push(7'h02); push(7'h03); push(7'h04);
    arm_run(16'd4, 16'd3);
    do_sync("t4");
    check_pattern("t4_p0", 7'h01, 3, 1'b1);
    check("t4_p1_sw", 32'(switches), 32'h02);
    tick();
    abort = 1'b1;
    #1;
    check("t4_abort_rd", 32'(fifo_rd), 32'd0);
    tick();
    abort = 1'b0;
    check_end("t4", 16'd2, 1'b0);
    arm_run(16'd1, 16'd2);
    do_sync("t4r");
    check_pattern("t4r_p0", 7'h03, 2, 1'b0);
    check_end("t4r", 16'd1, 1'b0);

    // arm together with abort in IDLE: ignored
    arm = 1'b1;
    abort = 1'b1;
    num_patterns = 16'd2;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("t5_armabort_busy", 32'(busy), 32'd0);
    check("t5_armabort_done", 32'(done), 32'd0);
    check("t5_armabort_count", 32'(played_count), 32'd1);

    // N=0: done next cycle, no pop
    arm = 1'b1;
    num_patterns = 16'd0;
    #1;
    check("t5_n0_rd", 32'(fifo_rd), 32'd0);
    tick();
    arm = 1'b0;
    check("t5_n0_done", 32'(done), 32'd1);
    check("t5_n0_busy", 32'(busy), 32'd0);
    check("t5_n0_count", 32'(played_count), 32'd0);
    tick();
    check("t5_n0_pulse", 32'(done), 32'd0);

    // arm while busy leaves latched D and N unchanged (04 is still queued)
    push(7'h0a); push(7'h0b);
    arm_run(16'd2, 16'd2);
    arm_run(16'd5, 16'd6);
    check("t6_busy", 32'(busy), 32'd1);
    do_sync("t6");
    check_pattern("t6_p0", 7'h04, 2, 1'b1);
    check_pattern("t6_p1", 7'h0a, 2, 1'b0);
    check_end("t6", 16'd2, 1'b0);

    // Reset mid-dwell, then sync ignored
    arm_run(16'd1, 16'd6);
    do_sync("t7");
    check("t7_sw", 32'(switches), 32'h0b);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t7_rst_sw", 32'(switches), 32'd0);
    check("t7_rst_valid", 32'(switches_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_done", 32'(done), 32'd0);
    check("t7_rst_count", 32'(played_count), 32'd0);
    push(7'h0c);
    sync = 1'b1;
    #1;
    check("t7_sync_rd", 32'(fifo_rd), 32'd0);
    tick();
    sync = 1'b0;
    check("t7_sync_busy", 32'(busy), 32'd0);
    check("t7_sync_sw", 32'(switches), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
